// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Digit counter width; never zero so a single-digit build still has a counter bit.
  function automatic int cntWidth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the adder.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );

endinterface

// File: rtl/digit_serial_adder_digit_rca.sv
// One-bit full adder cell and the DIGIT-bit ripple-carry slice built from it.
module full_addr (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module digit_rca
  import digit_serial_adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] carry;

  assign carry[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_addr u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(carry[i]),
      .s (s[i]),
      .co(carry[i+1])
    );
  end

  assign co       = carry[DIGIT];
  assign c_msb_in = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, lowest digit first, valid/ready on both sides.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  digit_serial_adder_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cntWidth(N);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CNT_W-1:0] k_q;

  logic [DIGIT-1:0] digA;
  logic [DIGIT-1:0] digB;
  logic [DIGIT-1:0] digS;
  logic             digCo;
  logic             digCmsb;
  logic             lastDigit;

  assign digA      = opA_q[k_q*DIGIT +: DIGIT];
  assign digB      = opB_q[k_q*DIGIT +: DIGIT];
  assign lastDigit = (k_q == LAST_K);

  digit_rca #(
    .DIGIT(DIGIT)
  ) u_rca (
    .a       (digA),
    .b       (digB),
    .ci      (carry_q),
    .s       (digS),
    .co      (digCo),
    .c_msb_in(digCmsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, step through N digits, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (lastDigit)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // Datapath: latch operands on accept (B inverted and carry forced to 1 for subtract), then fill S one digit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q   <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opA_q   <= bus.A;
            opB_q   <= bus.sub ? ~bus.B : bus.B;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            sum_q   <= '0;
            k_q     <= '0;
          end
        end
        RUN: begin
          sum_q[k_q*DIGIT +: DIGIT] <= digS;
          carry_q                   <= digCo;
          if (lastDigit) begin
            k_q    <= '0;
            cout_q <= digCo;
            ovf_q  <= digCmsb ^ digCo;
          end else begin
            k_q <= k_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.S    = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder, including a (WIDTH,DIGIT) sweep.
module tb_digit_serial_adder;

  logic clk;
  logic rst;

  int checks;
  int failures;

  digit_serial_adder_if #(.WIDTH(16)) bus0 ();
  digit_serial_adder_if #(.WIDTH(16)) bus1 ();
  digit_serial_adder_if #(.WIDTH(16)) bus2 ();
  digit_serial_adder_if #(.WIDTH(32)) bus3 ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  digit_serial_adder #(.WIDTH(16), .DIGIT(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  digit_serial_adder #(.WIDTH(32), .DIGIT(8))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one operation to dut0, let it be accepted, and count edges (accept edge = 1) until out_valid.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s, output int lat);
    bus0.A        = a;
    bus0.B        = b;
    bus0.cin      = c;
    bus0.sub      = s;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    bus0.A        = 16'hDEAD;
    bus0.B        = 16'hBEEF;
    lat = 1;
    while (!bus0.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Complete the output handshake on dut0.
  task automatic drainResult();
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
  endtask

  int lat;
  int lat1, lat2, lat3;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus0.in_valid = 0; bus0.A = '0; bus0.B = '0; bus0.cin = 0; bus0.sub = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.A = '0; bus1.B = '0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 0;
    bus2.in_valid = 0; bus2.A = '0; bus2.B = '0; bus2.cin = 0; bus2.sub = 0; bus2.out_ready = 0;
    bus3.in_valid = 0; bus3.A = '0; bus3.B = '0; bus3.cin = 0; bus3.sub = 0; bus3.out_ready = 0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_in_ready",  64'(bus0.in_ready),  64'd1);
    checkOutput("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    checkOutput("rst_S",         64'(bus0.S),         64'h0);
    checkOutput("rst_cout",      64'(bus0.cout),      64'd0);
    checkOutput("rst_ovf",       64'(bus0.ovf),       64'd0);

    // Basic add with latency
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    checkOutput("add_lat", 64'(lat), 64'd5);
    checkOutput("add_res", {61'(bus0.S), bus0.cout, bus0.ovf}, {61'h5555, 1'b0, 1'b0});
    drainResult();
    checkOutput("add_drain_valid", 64'(bus0.out_valid), 64'd0);

    // Full carry chain
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checkOutput("chain1_res", {61'(bus0.S), bus0.cout, bus0.ovf}, {61'h0000, 1'b1, 1'b0});
    drainResult();
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
    checkOutput("chain_cin_res", {61'(bus0.S), bus0.cout, bus0.ovf}, {61'h0000, 1'b1, 1'b0});
    drainResult();

    // Subtract, cin must be ignored
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    checkOutput("sub_neg_res", {61'(bus0.S), bus0.cout, bus0.ovf}, {61'hFFFE, 1'b0, 1'b0});
    drainResult();
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    checkOutput("sub_ovf_res", {61'(bus0.S), bus0.cout, bus0.ovf}, {61'h7FFF, 1'b1, 1'b1});
    drainResult();

    // Signed overflow on add with in_valid held high through RUN
    bus0.A = 16'h7FFF; bus0.B = 16'h0001; bus0.cin = 1'b0; bus0.sub = 1'b0;
    bus0.in_valid = 1'b1;
    tick();
    bus0.A = 16'h1111; bus0.B = 16'h2222;
    tick();
    checkOutput("hold_in_ready_run", 64'(bus0.in_ready), 64'd0);
    lat = 2;
    while (!bus0.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("hold_lat", 64'(lat), 64'd5);
    checkOutput("hold_res", {61'(bus0.S), bus0.cout, bus0.ovf}, {61'h8000, 1'b0, 1'b1});
    bus0.in_valid = 1'b0;
    drainResult();

    // Backpressure: result must sit unchanged while out_ready is low
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold", {60'(bus0.S), bus0.out_valid, bus0.cout, bus0.ovf}, {60'h1000, 1'b1, 1'b0, 1'b0});
      tick();
    end
    // Release and immediately offer the next operation
    bus0.A = 16'h0001; bus0.B = 16'h0002; bus0.cin = 1'b0; bus0.sub = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    checkOutput("bb_idle", {62'd0, bus0.in_ready, bus0.out_valid}, {62'd0, 1'b1, 1'b0});
    checkOutput("bb_keep_S", 64'(bus0.S), 64'h1000);
    tick();
    bus0.in_valid = 1'b0;
    lat = 1;
    while (!bus0.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("bb_lat", 64'(lat), 64'd5);
    checkOutput("bb_res", {61'(bus0.S), bus0.cout, bus0.ovf}, {61'h0003, 1'b0, 1'b0});
    drainResult();

    // Reset while RUN is on digit 2
    bus0.A = 16'h1234; bus0.B = 16'h4321; bus0.cin = 1'b0; bus0.sub = 1'b0;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_state", {62'd0, bus0.in_ready, bus0.out_valid}, {62'd0, 1'b1, 1'b0});
    checkOutput("midrst_S", 64'(bus0.S), 64'h0);
    tick();
    checkOutput("midrst_stay_idle", {62'd0, bus0.in_ready, bus0.out_valid}, {62'd0, 1'b1, 1'b0});

    // Parameter sweep: same addition on (16,1), (16,16), (32,8) accepted together
    bus1.A = 16'h1234; bus1.B = 16'h4321; bus1.in_valid = 1'b1;
    bus2.A = 16'h1234; bus2.B = 16'h4321; bus2.in_valid = 1'b1;
    bus3.A = 32'h0000_1234; bus3.B = 32'h0000_4321; bus3.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat3 = 0;
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (bus1.out_valid && lat1 == 0) lat1 = c;
      if (bus2.out_valid && lat2 == 0) lat2 = c;
      if (bus3.out_valid && lat3 == 0) lat3 = c;
    end
    checkOutput("sweep_d1_lat",  64'(lat1), 64'd17);
    checkOutput("sweep_d16_lat", 64'(lat2), 64'd2);
    checkOutput("sweep_w32_lat", 64'(lat3), 64'd5);
    checkOutput("sweep_d1_res",  {61'(bus1.S), bus1.cout, bus1.ovf}, {61'h5555, 1'b0, 1'b0});
    checkOutput("sweep_d16_res", {61'(bus2.S), bus2.cout, bus2.ovf}, {61'h5555, 1'b0, 1'b0});
    checkOutput("sweep_w32_res", {61'(bus3.S), bus3.cout, bus3.ovf}, {61'h0000_5555, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
